ssd_multichannel_scan: RTL and testbench
========================================

Name: ssd_multichannel_scan

Overview:
- Parametrised successor to the single-number seven-segment `counter` driver.
- Displays NUM_CH independent binary values (e.g. numSuns, zombiesKilled) side by side on one multiplexed seven-segment bank.
- Each channel has DIGITS_PER_CH decimal digits and optional leading-zero blanking.
- Binary-to-BCD conversion is sequential (double-dabble, round-robin over channels); values that do not fit are shown as dashes.
- Sits between the game logic and the board An*/Ca..Cg pins.

Parameters:
- NUM_CH, 2, number of independent display channels.
- DIGITS_PER_CH, 4, decimal digits per channel. NUM_CH*DIGITS_PER_CH must be ≤ 8.
- BIN_W, 16, width of each channel's binary input.
- REFRESH_BITS, 17, digit dwell is 2^REFRESH_BITS clk cycles.

Ports:
- clk  in  1  system clock (ClkPort)
- reset_n  in  1  synchronous active-low reset
- value_in  in  NUM_CH*BIN_W  packed channel values; channel k = value_in[k*BIN_W +: BIN_W]
- blank_lz  in  1  1 = blank leading zeros per channel
- enable  in  1  0 = all digits dark
- anode  out  NUM_CH*DIGITS_PER_CH  active-low digit enables; bit 0 = rightmost digit
- ssdOut  out  7  active-low segments; bit6 = a ... bit0 = g
- overflow  out  NUM_CH  1 = channel value ≥ 10^DIGITS_PER_CH
- conv_busy  out  1  1 while a conversion is in LOAD/SHIFT/STORE

Behaviour:
Clock and reset
- Single clock domain. Reset is synchronous and active-low.
- Reset values: anode all 1, ssdOut 7'h7F, overflow 0, conv_busy 0, display BCD registers 0, refresh counter 0, digit index 0, channel pointer 0, FSM IDLE.
- Reset asserted mid-conversion aborts the conversion; nothing partial is stored.

Conversion FSM (states IDLE, LOAD, SHIFT, STORE)
- IDLE → LOAD unconditionally, so LOAD occurs on the first cycle after reset release.
- LOAD:
  - Capture channel[ptr] value.
  - Compute ovf = (value ≥ 10^DIGITS_PER_CH) using a parameter-derived constant; tie ovf to 0 if 2^BIN_W ≤ 10^DIGITS_PER_CH.
  - Clear the BCD shift register (4*DIGITS_PER_CH bits).
  - conv_busy = 1.
- SHIFT, exactly BIN_W cycles. Each cycle:
  - add 3 to every BCD nibble ≥ 5;
  - then shift {bcd, bin} left by 1, MSB of bin entering the bcd LSB.
- STORE (1 cycle):
  - write the BCD result and overflow[ptr] = ovf into the display registers of channel ptr;
  - ptr = (ptr+1) mod NUM_CH;
  - go to LOAD.
- conv_busy is 0 only in IDLE.
- One channel takes BIN_W+2 cycles. Conversion runs continuously regardless of enable.
- Changes on value_in between LOADs for a channel are ignored until that channel's next LOAD.
- Display registers change only in STORE, so a partial result is never displayed.

Scan
- The refresh counter is free-running. On wrap (all ones → 0), the digit index increments.
- The digit index wraps from NUM_CH*DIGITS_PER_CH-1 to 0.
- Digit index d maps to channel = d / DIGITS_PER_CH and position p = d mod DIGITS_PER_CH (p = 0 is least significant). Channel 0 drives the lowest anodes.
- anode and ssdOut are registered: exactly 1-cycle latency from a digit-index change to the pins.
- anode is one-hot-low at bit d when enable = 1. When enable = 0, anode is all 1 and ssdOut is 7'h7F; scanning continues.

Segment selection, in priority order
1. overflow[channel] = 1 → dash 7'b1111110 on every digit of that channel.
2. blank_lz = 1, p ≠ 0, and this nibble and all more-significant nibbles of the channel are 0 → blank 7'h7F.
3. Otherwise decode the nibble:
   - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
   - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- Position 0 of a channel is never blanked (0 shows "0").

Test Plan:
All tests use REFRESH_BITS=2, NUM_CH=2, DIGITS_PER_CH=4, BIN_W=16.
- Reset: hold reset_n=0 for 5 cycles → anode=8'hFF, ssdOut=7'h7F, overflow=2'b00, conv_busy=0. Release → conv_busy=1 on the next cycle.
- Conversion: ch0=1234, ch1=50, blank_lz=0, enable=1; wait 2*(18) cycles, then scan 8 digits.
  - Required digits d0..d7: 4,3,2,1,0,5,0,0.
  - anode cycles FE, FD, … 7F with a dwell of 4 cycles.
- Leading-zero blanking: same values, blank_lz=1 → d6 and d7 blank (7F), d4=0 (0000001), d5=5. ch1=0 → only d4 shows "0".
- Overflow: ch0=10000 → overflow[0]=1 after its STORE; d0..d3 = 1111110; ch1 is unaffected. Then ch0=9999 → overflow[0]=0 and the display shows 9999.
- Stability and enable: change ch0 from 1234 to 4321 mid-SHIFT → ch0 display stays 1234 until the next ch0 STORE, then shows 4321. enable=0 → anode=FF, ssdOut=7F one cycle later.
- Reset mid-SHIFT: assert reset_n=0 during SHIFT of ch1 → display registers 0, ptr 0. After release, ch0 converts first.

Source files
------------

// File: rtl/ssd_multichannel_scan.sv
// rtl/ssd_multichannel_scan.sv - multi-channel binary-to-BCD seven-segment scan driver
// Round-robin double-dabble conversion feeds per-channel display registers that a refresh scan shows.
module ssd_multichannel_scan #(
  parameter int NUM_CH        = 2,
  parameter int DIGITS_PER_CH = 4,
  parameter int BIN_W         = 16,
  parameter int REFRESH_BITS  = 17
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_CH*BIN_W-1:0]         value_in,
  input  logic                            blank_lz,
  input  logic                            enable,
  output logic [NUM_CH*DIGITS_PER_CH-1:0] anode,
  output logic [6:0]                      ssdOut,
  output logic [NUM_CH-1:0]               overflow,
  output logic                            conv_busy
);

  localparam int TOTAL = NUM_CH * DIGITS_PER_CH;
  localparam int BCD_W = 4 * DIGITS_PER_CH;
  localparam int DIG_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]      LIMIT   = pow10(DIGITS_PER_CH);
  // Overflow detection only exists when the input can actually exceed the digit range.
  localparam bit               OVF_EN  = (BIN_W >= 64) || ((64'd1 << BIN_W) > LIMIT);
  localparam logic [BIN_W-1:0] LIMIT_B = BIN_W'(LIMIT);

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

  state_t                       state_q, state_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [BIN_W-1:0]             bin_q, bin_d;
  logic [BCD_W-1:0]             bcd_q, bcd_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         ovf_q, ovf_d;
  logic [NUM_CH-1:0][BCD_W-1:0] disp_q, disp_d;
  logic [NUM_CH-1:0]            ovfl_q, ovfl_d;
  logic [REFRESH_BITS-1:0]      refresh_q, refresh_d;
  logic [DIG_W-1:0]             digit_q, digit_d;
  logic [TOTAL-1:0]             anode_q, anode_d;
  logic [6:0]                   seg_q, seg_d;

  logic [BIN_W-1:0] val_sel;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] sel_bcd;
  logic             sel_ovf;
  logic [3:0]       nib;
  logic             upper_zero;
  logic [6:0]       seg_sel;
  int               ch_i;
  int               pos_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    ovfl_d  = ovfl_q;
    val_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (PTR_W'(c) == ptr_q) val_sel = value_in[c*BIN_W +: BIN_W];
    bcd_adj = bcd_q;
    for (int j = 0; j < DIGITS_PER_CH; j++)
      if (bcd_q[j*4 +: 4] >= 4'd5) bcd_adj[j*4 +: 4] = bcd_q[j*4 +: 4] + 4'd3;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        bin_d   = val_sel;
        ovf_d   = OVF_EN && (val_sel >= LIMIT_B);
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = STORE;
      end
      STORE: begin
        for (int c = 0; c < NUM_CH; c++)
          if (PTR_W'(c) == ptr_q) begin
            disp_d[c] = bcd_q;
            ovfl_d[c] = ovf_q;
          end
        ptr_d   = (ptr_q == PTR_W'(NUM_CH - 1)) ? '0 : ptr_q + PTR_W'(1);
        state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    refresh_d = refresh_q + REFRESH_BITS'(1);
    digit_d   = digit_q;
    if (&refresh_q) digit_d = (digit_q == DIG_W'(TOTAL - 1)) ? '0 : digit_q + DIG_W'(1);
    ch_i    = int'(digit_q) / DIGITS_PER_CH;
    pos_i   = int'(digit_q) % DIGITS_PER_CH;
    sel_bcd = '0;
    sel_ovf = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (c == ch_i) begin
        sel_bcd = disp_q[c];
        sel_ovf = ovfl_q[c];
      end
    nib        = '0;
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS_PER_CH; j++) begin
      if (j == pos_i) nib = sel_bcd[j*4 +: 4];
      if (j >= pos_i && sel_bcd[j*4 +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (sel_ovf)                                 seg_sel = SEG_DASH;
    else if (blank_lz && pos_i != 0 && upper_zero) seg_sel = SEG_BLANK;
    else                                         seg_sel = seg_decode(nib);
    anode_d = '1;
    seg_d   = SEG_BLANK;
    if (enable) begin
      for (int d = 0; d < TOTAL; d++)
        if (d == int'(digit_q)) anode_d[d] = 1'b0;
      seg_d = seg_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      disp_q    <= '0;
      ovfl_q    <= '0;
      refresh_q <= '0;
      digit_q   <= '0;
      anode_q   <= '1;
      seg_q     <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      disp_q    <= disp_d;
      ovfl_q    <= ovfl_d;
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
    end
  end

  assign anode     = anode_q;
  assign ssdOut    = seg_q;
  assign overflow  = ovfl_q;
  assign conv_busy = (state_q != IDLE);

endmodule

// File: tb/tb_ssd_multichannel_scan.sv
// tb/tb_ssd_multichannel_scan.sv - directed self-checking bench for ssd_multichannel_scan
// Digit patterns are packed one nibble per digit (d7..d0); A = dash, B = blank.
module tb_ssd_multichannel_scan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] value_in;
  logic        blank_lz;
  logic        enable;
  logic [7:0]  anode;
  logic [6:0]  ssdOut;
  logic [1:0]  overflow;
  logic        conv_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ssd_multichannel_scan #(
    .NUM_CH(2), .DIGITS_PER_CH(4), .BIN_W(16), .REFRESH_BITS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .blank_lz(blank_lz),
    .enable(enable), .anode(anode), .ssdOut(ssdOut), .overflow(overflow),
    .conv_busy(conv_busy)
  );

  function automatic logic [6:0] exp_seg(input logic [3:0] code);
    case (code)
      4'h0:    return 7'b0000001;
      4'h1:    return 7'b1001111;
      4'h2:    return 7'b0010010;
      4'h3:    return 7'b0000110;
      4'h4:    return 7'b1001100;
      4'h5:    return 7'b0100100;
      4'h6:    return 7'b0100000;
      4'h7:    return 7'b0001111;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0000100;
      4'hA:    return 7'b1111110;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_vals(input int c0, input int c1);
    value_in = {16'(c1), 16'(c0)};
  endtask

  task automatic scan(input string tag, input logic [31:0] pat, input int first, input int last);
    logic [7:0] want;
    int         k;
    for (int d = first; d <= last; d++) begin
      want = ~(8'b1 << d);
      k    = 0;
      while (anode !== want && k < 40) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("%s_an%0d", tag, d), 32'(anode), 32'(want));
      check($sformatf("%s_d%0d", tag, d), 32'(ssdOut), 32'(exp_seg(pat[d*4 +: 4])));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n  = 1'b0;
    blank_lz = 1'b0;
    enable   = 1'b1;
    set_vals(1234, 50);
    repeat (5) @(negedge clk);
    check("rst_anode", 32'(anode), 32'hFF);
    check("rst_seg", 32'(ssdOut), 32'h7F);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_busy", 32'(conv_busy), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("busy_release", 32'(conv_busy), 32'h1);

    repeat (39) @(negedge clk);
    scan("conv", 32'h0050_1234, 0, 7);
    check("conv_ovf", 32'(overflow), 32'h0);

    scan("dwell_pre", 32'h0050_1234, 1, 1);
    k = 0;
    while (anode == 8'hFD && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("dwell_len", 32'(k), 32'd4);
    check("dwell_next", 32'(anode), 32'hFB);

    blank_lz = 1'b1;
    scan("lz", 32'hBB50_1234, 0, 7);
    set_vals(1234, 0);
    repeat (54) @(negedge clk);
    scan("lz_zero", 32'hBBB0_1234, 4, 7);

    blank_lz = 1'b0;
    set_vals(10000, 0);
    repeat (54) @(negedge clk);
    check("ovf_set", 32'(overflow), 32'h1);
    scan("ovf", 32'h0000_AAAA, 0, 7);
    set_vals(9999, 0);
    repeat (54) @(negedge clk);
    check("ovf_clr", 32'(overflow), 32'h0);
    scan("ovf_9999", 32'h0000_9999, 0, 7);

    // ch0 captured at the 38th edge after release; the change lands in its SHIFT window.
    set_vals(1234, 50);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    set_vals(4321, 50);
    scan("stab_old", 32'h0050_1234, 0, 3);
    scan("stab_new", 32'h0050_4321, 0, 7);

    enable = 1'b0;
    @(negedge clk);
    check("en_off_anode", 32'(anode), 32'hFF);
    check("en_off_seg", 32'(ssdOut), 32'h7F);
    enable = 1'b1;
    scan("en_on", 32'h0050_4321, 4, 5);
    check("busy_run", 32'(conv_busy), 32'h1);

    // ch1 is mid-SHIFT at the 60th edge after release.
    set_vals(1234, 50);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_busy", 32'(conv_busy), 32'h0);
    check("mid_rst_ovf", 32'(overflow), 32'h0);
    check("mid_rst_anode", 32'(anode), 32'hFF);
    reset_n = 1'b1;
    scan("mid_rst_clr", 32'h0000_0000, 0, 7);
    scan("mid_rst_ch0", 32'h0050_1234, 0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
